// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // Width of a counter that must reach clocks_per_bit-1.
  function automatic int cycle_count_width(input int clocks_per_bit);
    return (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO: head holds the oldest entry (0 when empty); a pop on a
// full FIFO frees the slot for a push in the same cycle.
module uart_rx_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  input  logic                   pop,
  output logic [width-1:0]       head,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0]      COUNT_FULL = (AW+1)'(depth);
  localparam logic [AW:0]      COUNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]      COUNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW-1:0]    PTR_ONE    = AW'(1'b1);
  localparam logic [width-1:0] DATA_ZERO  = {width{1'b0}};

  logic [width-1:0] mem_r [depth];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [AW:0]      count_r, count_s;
  logic [width-1:0] head_r, head_s;
  logic             full_r, empty_r, full_s, empty_s;
  logic             push_ok_s, pop_ok_s;

  // Next pointers, occupancy and registered show-ahead head.
  always_comb begin
    pop_ok_s  = pop & ~empty_r;
    push_ok_s = push & (~full_r | pop_ok_s);
    wr_ptr_s  = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_s  = pop_ok_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + COUNT_ONE;
      2'b01:   count_s = count_r - COUNT_ONE;
      default: count_s = count_r;
    endcase
    full_s  = (count_s == COUNT_FULL);
    empty_s = (count_s == COUNT_ZERO);
    // The pushed byte becomes head only when it lands in an otherwise empty FIFO.
    if (empty_s) begin
      head_s = DATA_ZERO;
    end else if (push_ok_s && (empty_r || (pop_ok_s && (count_r == COUNT_ONE)))) begin
      head_s = push_data;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Storage and control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= COUNT_ZERO;
      head_r   <= DATA_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
      end
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      head_r   <= head_s;
      full_r   <= full_s;
      empty_r  <= empty_s;
    end
  end

  assign head  = head_r;
  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a byte FIFO,
// with one-cycle framing-error and overrun pulses.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4,
  parameter int fifo_depth     = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_rx,
  input  logic                        in_rd_en,
  output logic [7:0]                  out_rx_data,
  output logic                        out_rx_valid,
  output logic [$clog2(fifo_depth):0] out_count,
  output logic                        out_overrun,
  output logic                        out_frame_err
);

  localparam int CW = cycle_count_width(clocks_per_bit);
  localparam logic [CW-1:0] CYCLE_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CYCLE_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(clocks_per_bit / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(clocks_per_bit - 1);

  logic                      rx_meta_r, rx_s;
  uart_rx_state_t            state_r, state_s;
  logic [CW-1:0]             cycle_r, cycle_s;
  logic [2:0]                bit_r, bit_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_s;
  logic                      push_s, frame_err_s, overrun_s;
  logic                      frame_err_r, overrun_r;
  logic                      fifo_full_s, fifo_empty_s;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= in_rx;
      rx_s      <= rx_meta_r;
    end
  end

  // Frame FSM next state; all sampling decisions are made at counter terminal counts.
  always_comb begin
    state_s     = state_r;
    cycle_s     = cycle_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_s = START;
          cycle_s = CYCLE_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cycle_r == HALF_LAST) begin
          cycle_s = CYCLE_ZERO;
          bit_s   = 3'd0;
          state_s = rx_s ? IDLE : DATA;
        end else begin
          cycle_s = cycle_r + CYCLE_ONE;
        end
      end
      DATA: begin
        if (cycle_r == BIT_LAST) begin
          shift_s = {rx_s, shift_r[UART_DATA_BITS-1:1]};
          cycle_s = CYCLE_ZERO;
          bit_s   = bit_r + 3'd1;
          state_s = (bit_r == 3'd7) ? STOP : DATA;
        end else begin
          cycle_s = cycle_r + CYCLE_ONE;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cycle_r == BIT_LAST) begin
          cycle_s     = CYCLE_ZERO;
          state_s     = IDLE;
          push_s      = rx_s;
          frame_err_s = ~rx_s;
        end else begin
          cycle_s = cycle_r + CYCLE_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cycle_s = CYCLE_ZERO;
      end
    endcase
    // A pop on a full FIFO frees room for the push in the same cycle.
    overrun_s = push_s & fifo_full_s & ~in_rd_en;
  end

  // FSM, datapath and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      cycle_r     <= CYCLE_ZERO;
      bit_r       <= 3'd0;
      shift_r     <= {UART_DATA_BITS{1'b0}};
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cycle_r     <= cycle_s;
      bit_r       <= bit_s;
      shift_r     <= shift_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  uart_rx_fifo #(
    .width(UART_DATA_BITS),
    .depth(fifo_depth)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push_s),
    .push_data(shift_r),
    .pop      (in_rd_en),
    .head     (out_rx_data),
    .count    (out_count),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign out_rx_valid  = ~fifo_empty_s;
  assign out_overrun   = overrun_r;
  assign out_frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Randomised bench for uart_rx_buf: a model transmitter drives the line and a
// queue-based receiver model predicts FIFO contents and error pulses.
module tb_uart_rx_buf;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_rx;
  logic          in_rd_en;
  logic [7:0]    out_rx_data;
  logic          out_rx_valid;
  logic [NW-1:0] out_count;
  logic          out_overrun;
  logic          out_frame_err;

  uart_rx_buf #(
    .clocks_per_bit(CPB),
    .fifo_depth    (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_rx        (in_rx),
    .in_rd_en     (in_rd_en),
    .out_rx_data  (out_rx_data),
    .out_rx_valid (out_rx_valid),
    .out_count    (out_count),
    .out_overrun  (out_overrun),
    .out_frame_err(out_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int exp_fe   = 0;
  int exp_ov   = 0;
  logic [7:0] model_q [$];

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (out_overrun)   ov_seen = ov_seen + 1;
      if (out_frame_err) fe_seen = fe_seen + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_d;
    exp_d = (model_q.size() != 0) ? model_q[0] : 8'h00;
    check_val({tag, "_valid"}, {31'd0, out_rx_valid}, (model_q.size() != 0) ? 32'd1 : 32'd0);
    check_val({tag, "_data"},  {24'd0, out_rx_data}, {24'd0, exp_d});
    check_val({tag, "_count"}, 32'(out_count), 32'(model_q.size()));
  endtask

  task automatic check_pulses(input string tag);
    check_val({tag, "_overruns"},  32'(ov_seen), 32'(exp_ov));
    check_val({tag, "_frame_errs"}, 32'(fe_seen), 32'(exp_fe));
  endtask

  // Model transmitter: start bit, 8 data bits LSB first, stop bit, then idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      in_rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    in_rx = 1'b1;
  endtask

  task automatic send_model(input logic [7:0] b, input logic stop_ok);
    send_byte(b, stop_ok);
    if (!stop_ok) exp_fe = exp_fe + 1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ov = exp_ov + 1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk);
    check_state(tag);
    in_rd_en = 1'b1;
    @(negedge clk);
    in_rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic       ok;
    int         npops;

    resetn   = 1'b0;
    in_rx    = 1'b1;
    in_rd_en = 1'b0;
    #12;
    check_state("reset");
    check_val("reset_overrun",  {31'd0, out_overrun},   32'd0);
    check_val("reset_frameerr", {31'd0, out_frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // Single byte, then drain to empty.
    send_model(8'hA5, 1'b1);
    settle();
    check_val("t1_data", {24'd0, out_rx_data}, 32'h0000_00A5);
    check_state("t1_push");
    pop_one("t1_pop");
    @(negedge clk);
    check_state("t1_empty");

    // Back-to-back frames with no idle gap.
    send_model(8'h00, 1'b1);
    send_model(8'hFF, 1'b1);
    send_model(8'h3C, 1'b1);
    settle();
    check_state("t2_three");
    repeat (3) pop_one("t2_pop");
    @(negedge clk);
    check_state("t2_empty");

    // Five bytes into a four-deep FIFO: one overrun.
    for (int i = 1; i <= 5; i++) send_model(8'(i), 1'b1);
    settle();
    check_state("t3_full");
    check_pulses("t3");
    repeat (4) pop_one("t3_pop");

    // Full FIFO with a pop in the very cycle the new byte is pushed.
    for (int i = 0; i < DEPTH; i++) send_model(8'($urandom_range(0, 255)), 1'b1);
    settle();
    check_state("t4_prefill");
    fork
      send_byte(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (40) @(posedge clk);
        #1 in_rd_en = 1'b1;
        @(posedge clk);
        #1 in_rd_en = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_q.push_back(8'h77);
    settle();
    check_state("t4_swap");
    check_pulses("t4");
    repeat (4) pop_one("t4_pop");

    // Bad stop bit, then a clean byte.
    send_model(8'h55, 1'b0);
    repeat (CPB) @(posedge clk);
    settle();
    check_state("t5_ferr");
    check_pulses("t5");
    send_model(8'h12, 1'b1);
    settle();
    check_state("t5_after");
    pop_one("t5_pop");

    // One-cycle glitch on the idle line.
    @(posedge clk);
    #1 in_rx = 1'b0;
    @(posedge clk);
    #1 in_rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_state("t6_glitch");
    check_pulses("t6_glitch");

    // Reset in the middle of a frame with data queued.
    send_model(8'h9A, 1'b1);
    settle();
    check_state("t6_prereset");
    @(posedge clk);
    #1 in_rx = 1'b0;
    repeat (14) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    model_q.delete();
    check_state("t6_reset");
    check_val("t6_reset_overrun",  {31'd0, out_overrun},   32'd0);
    check_val("t6_reset_frameerr", {31'd0, out_frame_err}, 32'd0);
    in_rx = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    send_model(8'hC3, 1'b1);
    settle();
    check_state("t6_c3");
    check_pulses("t6_post");
    pop_one("t6_pop");

    // Random frames, occasional bad stop bits, random pops between frames.
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_model(rb, ok);
      if (!ok) repeat (CPB) @(posedge clk);
      else repeat ($urandom_range(0, 3)) @(posedge clk);
      npops = $urandom_range(0, 2);
      if (npops > 0) begin
        settle();
        for (int k = 0; k < npops; k++) pop_one("rnd_pop");
      end
    end
    settle();
    check_state("rnd_end");
    check_pulses("rnd_end");
    for (int k = 0; k <= DEPTH; k++) pop_one("rnd_drain");
    @(negedge clk);
    check_state("rnd_empty");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
